// File: rtl/dedicated_processor_param_if.sv
// ----------------------------------------------------------------------------
// dedicated_processor_param_if: start/done handshake and result bus.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dedicated_processor_param_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] limit;
  logic              busy;
  logic              done;
  logic              err;
  logic              overflow;
  logic [DATA_W-1:0] OutPort;

  modport master (
    output start, mode, limit,
    input  busy, done, err, overflow, OutPort
  );

  modport slave (
    input  start, mode, limit,
    output busy, done, err, overflow, OutPort
  );
endinterface

`default_nettype wire

// File: rtl/dedicated_processor_param.sv
// ----------------------------------------------------------------------------
// dedicated_processor_param: FSM-driven RF/adder datapath running SUM, FIB or COUNT.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dedicated_processor_param #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  dedicated_processor_param_if.slave bus
);

  localparam int AW = $clog2(RF_DEPTH);
  localparam logic [AW-1:0] c_r1 = AW'(1);
  localparam logic [AW-1:0] c_r2 = AW'(2);
  localparam logic [AW-1:0] c_r3 = AW'(3);
  localparam logic [1:0] c_sum   = 2'd0;
  localparam logic [1:0] c_fib   = 2'd1;
  localparam logic [1:0] c_count = 2'd2;
  localparam logic [1:0] c_bad   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CMP, S_INC, S_ACC, S_OUT, S_DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_rf [RF_DEPTH];
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_limit;
  logic [1:0]        r_mode;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_ovf;
  logic [DATA_W-1:0] r_out;

  logic              w_add_en;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;

  // Single shared adder; operands are zero when no add is scheduled so the
  // carry can only flag real ALU operations.
  always_comb begin
    w_add_en = 1'b0;
    w_a      = '0;
    w_b      = '0;
    case (r_state)
      S_INC: begin
        w_add_en = 1'b1;
        w_a      = r_rf[c_r1];
        w_b      = (r_mode == c_fib) ? r_rf[c_r2] : DATA_W'(1);
      end
      S_ACC: begin
        if (r_mode == c_sum) begin
          w_add_en = 1'b1;
          w_a      = r_rf[c_r2];
          w_b      = r_rf[c_r1];
        end
      end
      default: ;
    endcase
  end

  assign {w_carry, w_sum} = {1'b0, w_a} + {1'b0, w_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
      r_cnt   <= '0;
      r_limit <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_add_en && w_carry) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_limit <= bus.limit;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_cnt      <= '0;
          r_out      <= '0;
          r_ovf      <= 1'b0;
          r_rf[c_r1] <= '0;
          r_rf[c_r2] <= (r_mode == c_fib) ? DATA_W'(1) : '0;
          r_rf[c_r3] <= '0;
          if (r_mode == c_bad) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (r_cnt < r_limit) begin
            r_state <= S_INC;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_INC: begin
          if (r_mode == c_fib) r_rf[c_r3] <= w_sum;
          else                 r_rf[c_r1] <= w_sum;
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_mode == c_sum)      r_rf[c_r2] <= w_sum;
          else if (r_mode == c_fib) r_rf[c_r1] <= r_rf[c_r2];
          r_state <= S_OUT;
        end
        S_OUT: begin
          case (r_mode)
            c_sum:   r_out <= r_rf[c_r2];
            c_fib: begin
              r_rf[c_r2] <= r_rf[c_r3];
              r_out      <= r_rf[c_r1];
            end
            c_count: r_out <= r_rf[c_r1];
            default: ;
          endcase
          r_cnt   <= r_cnt + DATA_W'(1);
          r_state <= S_CMP;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.overflow = r_ovf;
  assign bus.OutPort  = r_out;

endmodule

`default_nettype wire

// File: tb/tb_dedicated_processor_param.sv
// ----------------------------------------------------------------------------
// tb_dedicated_processor_param: directed checks of SUM/FIB/COUNT runs, edge cases and reset.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dedicated_processor_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dedicated_processor_param_if #(.DATA_W(8))  bus8 ();
  dedicated_processor_param_if #(.DATA_W(16)) bus16 ();

  dedicated_processor_param #(.DATA_W(8), .RF_DEPTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  dedicated_processor_param #(.DATA_W(16), .RF_DEPTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          done_cyc;
  int          done_cnt;
  logic        err_at_done;
  logic        busy_ok;
  logic        post_busy;
  logic        post_done;
  logic        seen_done;
  logic [31:0] hist[$];
  int          fibv[6] = '{1, 1, 2, 3, 5, 8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle c (c>=1) is sampled 1ns after the c-th edge following the accepting edge 0;
  // hist[c-1] holds OutPort during cycle c.
  task automatic run8(input logic [1:0] m, input logic [7:0] n, input int pulse_at, input bit hold);
    hist.delete();
    done_cyc    = -1;
    done_cnt    = 0;
    busy_ok     = 1'b1;
    err_at_done = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.mode  = m;
    bus8.limit = n;
    @(posedge clk); #1;
    if (!hold) bus8.start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      hist.push_back(32'(bus8.OutPort));
      if (!bus8.busy) busy_ok = 1'b0;
      if (bus8.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          err_at_done = bus8.err;
        end
      end
      if (c == pulse_at) begin
        bus8.start = 1'b1;
        bus8.mode  = 2'd1;
        bus8.limit = 8'd3;
      end
      if (c == pulse_at + 1) begin
        bus8.start = 1'b0;
        bus8.mode  = m;
        bus8.limit = n;
      end
      if (done_cyc > 0) break;
      @(posedge clk); #1;
    end
    chk("done_within_budget", 32'(done_cnt), 32'd1);
    @(posedge clk); #1;
    post_busy = bus8.busy;
    post_done = bus8.done;
  endtask

  initial begin
    reset       = 1'b0;
    bus8.start  = 1'b0;
    bus8.mode   = 2'd0;
    bus8.limit  = 8'd0;
    bus16.start = 1'b0;
    bus16.mode  = 2'd0;
    bus16.limit = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    32'(bus8.busy),     32'd0);
    chk("rst_done",    32'(bus8.done),     32'd0);
    chk("rst_err",     32'(bus8.err),      32'd0);
    chk("rst_ovf",     32'(bus8.overflow), 32'd0);
    chk("rst_outport", 32'(bus8.OutPort),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // SUM 10: 1,3,6,...,55
    run8(2'd0, 8'd10, -5, 1'b0);
    chk("sum10_done_cyc", 32'(done_cyc), 32'd43);
    chk("sum10_busy_all", 32'(busy_ok), 32'd1);
    chk("sum10_err", 32'(err_at_done), 32'd0);
    chk("sum10_post_busy", 32'(post_busy), 32'd0);
    chk("sum10_post_done", 32'(post_done), 32'd0);
    for (int k = 1; k <= 10; k++) chk("sum10_seq", hist[4*k+1], 32'(k*(k+1)/2));
    chk("sum10_final", 32'(bus8.OutPort), 32'd55);
    chk("sum10_ovf", 32'(bus8.overflow), 32'd0);

    // FIB 12 / 13
    run8(2'd1, 8'd12, -5, 1'b0);
    chk("fib12_done_cyc", 32'(done_cyc), 32'd51);
    for (int k = 1; k <= 6; k++) chk("fib12_seq", hist[4*k+1], 32'(fibv[k-1]));
    chk("fib12_final", 32'(bus8.OutPort), 32'd144);
    chk("fib12_ovf", 32'(bus8.overflow), 32'd0);
    run8(2'd1, 8'd13, -5, 1'b0);
    chk("fib13_final", 32'(bus8.OutPort), 32'd233);
    chk("fib13_ovf", 32'(bus8.overflow), 32'd1);

    // SUM 23 wraps, then COUNT 5 clears overflow
    run8(2'd0, 8'd23, -5, 1'b0);
    chk("sum23_done_cyc", 32'(done_cyc), 32'd95);
    chk("sum23_final", 32'(bus8.OutPort), 32'd20);
    chk("sum23_ovf", 32'(bus8.overflow), 32'd1);
    run8(2'd2, 8'd5, -5, 1'b0);
    chk("cnt5_done_cyc", 32'(done_cyc), 32'd23);
    for (int k = 1; k <= 5; k++) chk("cnt5_seq", hist[4*k+1], 32'(k));
    chk("cnt5_ovf", 32'(bus8.overflow), 32'd0);

    // limit=0 and illegal mode
    run8(2'd0, 8'd0, -5, 1'b0);
    chk("lim0_done_cyc", 32'(done_cyc), 32'd3);
    chk("lim0_err", 32'(err_at_done), 32'd0);
    chk("lim0_outport", 32'(bus8.OutPort), 32'd0);
    run8(2'd2, 8'd3, -5, 1'b0);
    chk("cnt3_final", 32'(bus8.OutPort), 32'd3);
    run8(2'd3, 8'd7, -5, 1'b0);
    chk("bad_done_cyc", 32'(done_cyc), 32'd2);
    chk("bad_err", 32'(err_at_done), 32'd1);
    chk("bad_outport", 32'(bus8.OutPort), 32'd0);
    chk("bad_err_after", 32'(bus8.err), 32'd0);

    // limit = max: strict compare stops cnt from wrapping
    run8(2'd2, 8'd255, -5, 1'b0);
    chk("cnt255_done_cyc", 32'(done_cyc), 32'd1023);
    chk("cnt255_final", 32'(bus8.OutPort), 32'd255);
    chk("cnt255_ovf", 32'(bus8.overflow), 32'd0);

    // start pulsed mid-run is ignored
    run8(2'd0, 8'd10, 10, 1'b0);
    chk("pulse_done_cyc", 32'(done_cyc), 32'd43);
    chk("pulse_final", 32'(bus8.OutPort), 32'd55);
    chk("pulse_post_busy", 32'(post_busy), 32'd0);

    // asynchronous reset at cycle 20 of a SUM run
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.mode  = 2'd0;
    bus8.limit = 8'd10;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_outport", 32'(bus8.OutPort), 32'd10);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus8.busy), 32'd0);
    chk("arst_outport", 32'(bus8.OutPort), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus8.done) seen_done = 1'b1;
    end
    chk("arst_no_done", 32'(seen_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run8(2'd0, 8'd10, -5, 1'b0);
    chk("restart_done_cyc", 32'(done_cyc), 32'd43);
    chk("restart_final", 32'(bus8.OutPort), 32'd55);

    // start held high: one IDLE cycle then a fresh run
    run8(2'd2, 8'd2, -5, 1'b1);
    chk("hold_done_cyc", 32'(done_cyc), 32'd11);
    chk("hold_idle_gap", 32'(post_busy), 32'd0);
    @(posedge clk); #1;
    chk("hold_restart_busy", 32'(bus8.busy), 32'd1);
    bus8.start = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus8.done) seen_done = 1'b1;
      if (!bus8.busy) break;
    end
    chk("hold_second_done", 32'(seen_done), 32'd1);
    chk("hold_second_final", 32'(bus8.OutPort), 32'd2);

    // 16-bit instance: SUM 300 -> 45150
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.mode  = 2'd0;
    bus16.limit = 16'd300;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      if (bus16.done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w16_done_cyc", 32'(done_cyc), 32'd1203);
    chk("w16_final", 32'(bus16.OutPort), 32'd45150);
    chk("w16_ovf", 32'(bus16.overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dedicated_processor_param.md
Name: dedicated_processor_param

Overview:
- Parametrised multi-mode dedicated processor. A control FSM drives a datapath built from a register file, a single adder ALU, a loop counter and a less-than comparator.
- Runs one of three fixed algorithms on a start/done handshake: running sum 1..N, Fibonacci sequence, or count-up.
- Streams each iteration's result on OutPort.
- Standalone compute block; also a template for later programmable datapaths.

Parameters:
- DATA_W, 8: datapath, limit and OutPort width; minimum 4.
- RF_DEPTH, 8: register-file entries; power of 2, minimum 4; address width is clog2(RF_DEPTH).

Ports:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request pulse/level; sampled only in IDLE.
- mode  input  2  0=SUM, 1=FIB, 2=COUNT, 3=illegal; latched when start is accepted.
- limit  input  DATA_W  iteration count N, unsigned; latched when start is accepted.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in state DONE.
- err  output  1  high during the DONE pulse of an illegal-mode run; 0 otherwise.
- overflow  output  1  sticky carry-out flag for the current/last run.
- OutPort  output  DATA_W  latest iteration result; holds its value between runs.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, err, overflow, OutPort = 0.
  - Register file, loop counter cnt, mode_q and limit_q = 0.
  - Reset mid-run aborts immediately; no done pulse is produced.
- FSM states: IDLE, INIT, CMP, INC, ACC, OUT, DONE.
- IDLE:
  - start=1 at a rising edge: latch mode and limit, go to INIT.
  - start while busy is ignored; it is neither queued nor restarts the run.
- INIT (1 cycle):
  - cnt=0, OutPort=0, overflow=0.
  - R1=0; R2 = (mode_q==FIB) ? 1 : 0; R3=0.
  - If mode_q==3, go to DONE with err set; otherwise go to CMP.
- CMP: if cnt < limit_q (unsigned), go to INC; otherwise go to DONE.
- Per-mode actions. The register file has one write port, so at most one RF write per cycle.
  - SUM: INC R1<=R1+1; ACC R2<=R2+R1; OUT OutPort<=R2 (post-ACC value).
  - FIB: INC R3<=R1+R2; ACC R1<=R2; OUT R2<=R3 and OutPort<=R1 (new a). Output sequence is 1,1,2,3,5,8,...
  - COUNT: INC R1<=R1+1; ACC no write; OUT OutPort<=R1.
- OUT also increments cnt, then goes to CMP.
- Iteration cost is 4 cycles (CMP, INC, ACC, OUT).
- Latency, with cycle 0 being the edge that accepts start:
  - INIT occupies cycle 1.
  - Iteration k (1..N) occupies cycles 4k-2..4k+1.
  - The final CMP occupies cycle 4N+2.
  - done=1 during cycle 4N+3, then the FSM returns to IDLE.
- Arithmetic:
  - All adds are DATA_W wide and wrap modulo 2^DATA_W.
  - Any carry-out from any ALU add in the run sets overflow, including FIB's look-ahead term in R3.
  - overflow stays set until the next INIT.
- limit=0: no iterations; done in cycle 3; OutPort=0.
- limit = 2^DATA_W-1: cnt never wraps, because the compare is strict less-than.
- Illegal mode:
  - Sequence is INIT then DONE; done and err are high in cycle 2.
  - OutPort=0; no iterations run.
- start held high continuously: a new run begins on the edge after DONE returns to IDLE, i.e. one IDLE cycle between runs.
- Register indices R1..R3 are fixed. Entries above R3 are unused but must reset to 0.

Test Plan:
- SUM, limit=10, DATA_W=8 -> OutPort sequence 1,3,6,...,55; done pulse in cycle 43; overflow=0; busy high in cycles 1..43.
- FIB, limit=12 -> last OutPort=144, overflow=0. FIB, limit=13 -> OutPort=233, overflow=1 (R3=F(14)=377 carries).
- SUM, limit=23 -> OutPort=276 mod 256=20, overflow=1. A following COUNT run with limit=5 -> overflow cleared, OutPort sequence 1..5.
- limit=0 (any legal mode) -> done in cycle 3, OutPort=0. mode=3 -> done and err in cycle 2, OutPort=0.
- start pulsed while busy mid-SUM -> ignored, result unchanged. reset=0 at cycle 20 of a run -> all outputs 0 immediately, no done pulse; a restart after release produces the correct result.
- DATA_W=16, RF_DEPTH=16, SUM, limit=300 -> final OutPort=45150, overflow=0, done in cycle 1203.
